mem_access_ctrl: RTL

//  Sequencer between the execute stage and main memory for all loads and stores. Runs one memory access per accepted request.
//  - Stores: takes pre-formatted store data and byte enables from the store formatter.
//  - Loads: captures read data, selects the lane and sign/zero-extends it.
//  - Faults (misaligned, bad size, IO region addr[31]=1) and memory timeouts return an error response with no memory write.

---
 rtl/mau_pkg.sv | 35 +++
 rtl/mau_load_extract.sv | 34 +++
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states,
// response cause codes and the request fault classifier.
package mau_pkg;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Access fault (bad size or IO region) outranks misalignment.
  function automatic logic [1:0] req_cause(input logic [2:0] size,
                                           input logic       addr_io,
                                           input logic [1:0] addr_lo);
    logic [1:0] c;
    c = CAUSE_OK;
    if ((size != SZ_BYTE && size != SZ_HALF && size != SZ_WORD) || addr_io)
      c = CAUSE_ACCESS;
    else if ((size == SZ_HALF && addr_lo[0]) ||
             (size == SZ_WORD && addr_lo != 2'b00))
      c = CAUSE_MISALIGN;
    return c;
  endfunction

endpackage

// File: rtl/mau_load_extract.sv
// Combinational load lane select with sign/zero extension.
module mau_load_extract
  import mau_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = '0;
    case (addr_lo)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = '0;
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (size)
      SZ_BYTE: data = {{24{~zero_ext & lane_b[7]}}, lane_b};
      SZ_HALF: data = {{16{~zero_ext & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute stage and main memory.
// Optional access timeout enabled by defining MAU_TIMEOUT_EN.
module mem_access_ctrl
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause
);

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYC)) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT_CYC");
  end

  state_t      state;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [3:0]  wen_q;
  logic [31:0] rdata_q;
  logic [1:0]  cause_q;
  logic [1:0]  new_cause;
  logic [31:0] ld_data;
  logic        in_access;

`ifdef MAU_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
`endif

  assign new_cause = req_cause(req_size, req_addr[31], req_addr[1:0]);

  mau_load_extract u_extract (
    .rdata    (mem_rdata),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .zero_ext (uns_q),
    .data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      wen_q   <= '0;
      rdata_q <= '0;
      cause_q <= CAUSE_OK;
`ifdef MAU_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_we ? st_data : '0;
            wen_q   <= req_we ? st_wen : '0;
            rdata_q <= '0;
            cause_q <= new_cause;
`ifdef MAU_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            state   <= (new_cause == CAUSE_OK) ? ACCESS : FAULT;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rdata_q <= we_q ? '0 : ld_data;
            state   <= RESP;
          end
`ifdef MAU_TIMEOUT_EN
          // Counter value equals the number of completed wait cycles, so the
          // limit compare uses TIMEOUT_CYC-1 to hold mem_req TIMEOUT_CYC cycles.
          else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            cause_q <= CAUSE_TIMEOUT;
            state   <= FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP, FAULT: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access  = (state == ACCESS);
  assign req_ready  = (state == IDLE);
  assign mem_req    = in_access;
  assign mem_we     = in_access & we_q;
  assign mem_addr   = in_access ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata  = in_access ? wdata_q : '0;
  assign mem_wen    = in_access ? wen_q : '0;
  assign resp_valid = (state == RESP) || (state == FAULT);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && (cause_q != CAUSE_OK);
  assign resp_cause = resp_valid ? cause_q : CAUSE_OK;

endmodule
